// File: rtl/cache_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_axi_bridge_pkg
// Shared request-type encodings, AXI constants, FSM states and len/size helpers.
// Rev    : 1.0
// ============================================================================
package cache_axi_bridge_pkg;

    localparam logic [2:0] TYPE_BYTE  = 3'b000;
    localparam logic [2:0] TYPE_HALF  = 3'b001;
    localparam logic [2:0] TYPE_WORD  = 3'b010;
    localparam logic [2:0] TYPE_LINE  = 3'b100;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    function automatic logic [7:0] axi_len(input logic [2:0] req_type);
        return (req_type == TYPE_LINE) ? 8'd3 : 8'd0;
    endfunction

    // A line moves as four 32-bit beats; narrower requests use their own size.
    function automatic logic [2:0] axi_size(input logic [2:0] req_type);
        case (req_type)
            TYPE_BYTE: return 3'd0;
            TYPE_HALF: return 3'd1;
            TYPE_WORD: return 3'd2;
            TYPE_LINE: return 3'd2;
            default:   return {1'b0, req_type[1:0]};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : cache_axi_bridge_if
// AXI3 master-side bundle (AR/R/AW/W/B) between the bridge and the interconnect.
// Rev    : 1.0
// ============================================================================
interface cache_axi_bridge_if;
    import cache_axi_bridge_pkg::*;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface
`default_nettype wire

// File: rtl/cache_axi_bridge_axi_wr_beat_mux.sv
`default_nettype none
// ============================================================================
// Module : axi_wr_beat_mux
// Selects the current 32-bit W beat from the buffered line and flags the last beat.
// Rev    : 1.0
// ============================================================================
module axi_wr_beat_mux
    import cache_axi_bridge_pkg::*;
(
    input  logic [127:0] line,
    input  logic [1:0]   cnt,
    input  logic [1:0]   last_idx,
    output logic [31:0]  wdata,
    output logic         wlast
);
    always_comb begin
        case (cnt)
            2'd0:    wdata = line[31:0];
            2'd1:    wdata = line[63:32];
            2'd2:    wdata = line[95:64];
            default: wdata = line[127:96];
        endcase
    end

    assign wlast = (cnt == last_idx);
endmodule
`default_nettype wire

// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module : cache_axi_bridge
// Cache refill/writeback port to AXI3 master; one read and one write in flight.
// Option : RAW_LINE_CHECK_EN limits the read-after-write stall to the same 16B line.
// Rev    : 1.0
// ============================================================================
module cache_axi_bridge
    import cache_axi_bridge_pkg::*;
#(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_req,
    input  logic [2:0]         rd_type,
    input  logic [31:0]        rd_addr,
    output logic               rd_rdy,
    output logic               ret_valid,
    output logic               ret_last,
    output logic [31:0]        ret_data,
    input  logic               wr_req,
    input  logic [2:0]         wr_type,
    input  logic [31:0]        wr_addr,
    input  logic [3:0]         wr_wstrb,
    input  logic [127:0]       wr_data,
    output logic               wr_rdy,
    cache_axi_bridge_if.master axi
);
    rd_state_t    rd_state, rd_state_nxt;
    wr_state_t    wr_state, wr_state_nxt;

    logic [31:0]  rd_addr_q;
    logic [2:0]   rd_type_q;
    logic [31:0]  wr_addr_q;
    logic [2:0]   wr_type_q;
    logic [3:0]   wr_strb_q;
    logic [127:0] wr_data_q;
    logic [1:0]   beat_cnt;

    logic         rd_accept;
    logic         wr_accept;
    logic         wr_pending;
    logic         hazard;
    logic         w_fire;
    logic [7:0]   aw_len;
    logic         ar_valid, r_ready, aw_valid, w_valid, b_ready;
    logic         unused_axi_fields;

    assign wr_rdy     = (wr_state == W_IDLE);
    assign wr_accept  = wr_req & wr_rdy;
    assign wr_pending = (wr_state != W_IDLE);

    // The incoming write counts too, so a same-cycle read never overtakes it.
`ifdef RAW_LINE_CHECK_EN
    assign hazard = (wr_pending & (rd_addr[31:4] == wr_addr_q[31:4]))
                  | (wr_accept  & (rd_addr[31:4] == wr_addr[31:4]));
`else
    assign hazard = wr_pending | wr_accept;
`endif

    assign rd_rdy    = (rd_state == R_IDLE) & ~hazard;
    assign rd_accept = rd_req & rd_rdy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_addr_q <= '0;
            rd_type_q <= '0;
            wr_addr_q <= '0;
            wr_type_q <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
            beat_cnt  <= '0;
        end else begin
            if (rd_accept) begin
                rd_addr_q <= rd_addr;
                rd_type_q <= rd_type;
            end
            if (wr_accept) begin
                wr_addr_q <= wr_addr;
                wr_type_q <= wr_type;
                wr_strb_q <= wr_wstrb;
                wr_data_q <= wr_data;
                beat_cnt  <= 2'd0;
            end else if (w_fire) begin
                beat_cnt  <= beat_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        ar_valid     = 1'b0;
        r_ready      = 1'b0;
        case (rd_state)
            R_IDLE: if (rd_accept) rd_state_nxt = R_AR;
            R_AR: begin
                ar_valid = 1'b1;
                if (axi.arready) rd_state_nxt = R_DATA;
            end
            R_DATA: begin
                r_ready = 1'b1;
                if (axi.rvalid && axi.rlast) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        aw_valid     = 1'b0;
        w_valid      = 1'b0;
        b_ready      = 1'b0;
        case (wr_state)
            W_IDLE: if (wr_accept) wr_state_nxt = W_AW;
            W_AW: begin
                aw_valid = 1'b1;
                if (axi.awready) wr_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_valid = 1'b1;
                if (axi.wready && axi.wlast) wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_ready = 1'b1;
                if (axi.bvalid) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    assign w_fire = w_valid & axi.wready;
    assign aw_len = axi_len(wr_type_q);

    axi_wr_beat_mux u_beat_mux (
        .line     (wr_data_q),
        .cnt      (beat_cnt),
        .last_idx (aw_len[1:0]),
        .wdata    (axi.wdata),
        .wlast    (axi.wlast)
    );

    assign axi.arid    = RD_ID;
    assign axi.araddr  = rd_addr_q;
    assign axi.arlen   = axi_len(rd_type_q);
    assign axi.arsize  = axi_size(rd_type_q);
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = ar_valid;
    assign axi.rready  = r_ready;

    assign axi.awid    = WR_ID;
    assign axi.awaddr  = wr_addr_q;
    assign axi.awlen   = aw_len;
    assign axi.awsize  = axi_size(wr_type_q);
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = aw_valid;
    assign axi.wstrb   = (wr_type_q == TYPE_LINE) ? 4'hf : wr_strb_q;
    assign axi.wvalid  = w_valid;
    assign axi.bready  = b_ready;

    // Read data is a zero-latency pass-through; only the valid is qualified.
    assign ret_valid = (rd_state == R_DATA) & axi.rvalid;
    assign ret_last  = axi.rlast;
    assign ret_data  = axi.rdata;

    // IDs and responses carry no information for a single-outstanding master.
    assign unused_axi_fields = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};
endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge.sv
`default_nettype none
// Scoreboard bench for cache_axi_bridge: expected beats are queued as stimulus is
// driven and popped when the bridge returns or emits them.
module tb_cache_axi_bridge;
    import cache_axi_bridge_pkg::*;

`ifdef RAW_LINE_CHECK_EN
    localparam bit LINE_CHK = 1'b1;
`else
    localparam bit LINE_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t sb[$];
    beat_t exp_b;

    cache_axi_bridge_if axi ();

    cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_read(input int beats);
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int i = 0; i < beats; i++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = 32'h0;
            axi.rlast  = (i == beats - 1);
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    task automatic drain_write(input int beats);
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        for (int i = 0; i < beats; i++) tick();
        axi.wready = 1'b0;
        axi.bvalid = 1'b1;
        tick();
        axi.bvalid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_checks++; if (axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b want 0", axi.arvalid); end
        n_checks++; if (axi.awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b want 0", axi.awvalid); end
        n_checks++; if (axi.wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", axi.wvalid); end
        n_checks++; if (axi.rready !== 1'b0 || axi.bready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got rready=%b bready=%b want 0 0", axi.rready, axi.bready); end
        n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ret_valid: got %b want 0", ret_valid); end
        n_checks++; if (rd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got rd_rdy=%b wr_rdy=%b want 1 1", rd_rdy, wr_rdy); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_line_read();
        rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h1c00_0100;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL lr_accept: got rd_rdy=%b want 1", rd_rdy); end
        tick();
        rd_req = 1'b0;
        #1;
        n_checks++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1c00_0100) begin n_fail++; $display("FAIL lr_ar: got arvalid=%b araddr=%h want 1 1c000100", axi.arvalid, axi.araddr); end
        n_checks++; if (axi.arlen !== 8'd3 || axi.arsize !== 3'd2 || axi.arburst !== 2'b01 || axi.arid !== 4'd0) begin n_fail++; $display("FAIL lr_ar_attr: got len=%0d size=%0d burst=%b id=%0d want 3 2 01 0", axi.arlen, axi.arsize, axi.arburst, axi.arid); end
        for (int i = 0; i < 4; i++) sb.push_back('{data: 32'hA0 + i, last: (i == 3)});
        tick();
        tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        #1;
        n_checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1 || ret_valid !== 1'b0) begin n_fail++; $display("FAIL lr_rphase: got arvalid=%b rready=%b ret_valid=%b want 0 1 0", axi.arvalid, axi.rready, ret_valid); end
        for (int i = 0; i < 4; i++) begin
            axi.rvalid = 1'b1; axi.rdata = 32'hA0 + i; axi.rlast = (i == 3);
            #1;
            if (ret_valid && sb.size() > 0) begin
                exp_b = sb.pop_front();
                n_checks++; if (ret_data !== exp_b.data || ret_last !== exp_b.last) begin n_fail++; $display("FAIL lr_beat%0d: got data=%h last=%b want %h %b", i, ret_data, ret_last, exp_b.data, exp_b.last); end
            end else begin
                n_checks++; n_fail++; $display("FAIL lr_beat%0d_valid: got ret_valid=%b want 1", i, ret_valid);
            end
            tick();
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        n_checks++; if (axi.rready !== 1'b0 || rd_rdy !== 1'b1) begin n_fail++; $display("FAIL lr_done: got rready=%b rd_rdy=%b want 0 1", axi.rready, rd_rdy); end
        sb.delete();
    endtask

    task automatic test_word_read();
        rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0008;
        tick();
        rd_req = 1'b0;
        #1;
        n_checks++; if (axi.arlen !== 8'd0 || axi.arsize !== 3'd2 || axi.araddr !== 32'h8) begin n_fail++; $display("FAIL wr_rd_ar: got len=%0d size=%0d addr=%h want 0 2 00000008", axi.arlen, axi.arsize, axi.araddr); end
        sb.push_back('{data: 32'h5555_AAAA, last: 1'b1});
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = 32'h5555_AAAA; axi.rlast = 1'b1;
        #1;
        if (ret_valid && sb.size() > 0) begin
            exp_b = sb.pop_front();
            n_checks++; if (ret_data !== exp_b.data || ret_last !== exp_b.last) begin n_fail++; $display("FAIL word_beat: got data=%h last=%b want %h %b", ret_data, ret_last, exp_b.data, exp_b.last); end
        end else begin
            n_checks++; n_fail++; $display("FAIL word_beat_valid: got ret_valid=%b want 1", ret_valid);
        end
        n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL word_busy: got rd_rdy=%b want 0", rd_rdy); end
        tick();
        axi.rvalid = 1'b0; axi.rlast = 1'b0;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL word_rdy_back: got rd_rdy=%b want 1", rd_rdy); end
    endtask

    task automatic test_line_write();
        int beats;
        wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h0000_0200; wr_wstrb = 4'h0;
        wr_data = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        for (int i = 0; i < 4; i++) sb.push_back('{data: wr_data[i*32 +: 32], last: (i == 3)});
        #1;
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL lw_accept: got wr_rdy=%b want 1", wr_rdy); end
        tick();
        wr_req = 1'b0;
        #1;
        n_checks++; if (axi.awvalid !== 1'b1 || axi.awaddr !== 32'h200 || axi.awlen !== 8'd3 || axi.awsize !== 3'd2 || axi.awid !== 4'd1 || axi.awburst !== 2'b01) begin n_fail++; $display("FAIL lw_aw: got valid=%b addr=%h len=%0d size=%0d id=%0d burst=%b want 1 200 3 2 1 01", axi.awvalid, axi.awaddr, axi.awlen, axi.awsize, axi.awid, axi.awburst); end
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL lw_busy: got wr_rdy=%b want 0", wr_rdy); end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        beats = 0;
        for (int cyc = 0; cyc < 16 && beats < 4; cyc++) begin
            axi.wready = cyc[0];
            #1;
            if (axi.wvalid && axi.wready) begin
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    n_checks++; if (axi.wdata !== exp_b.data || axi.wlast !== exp_b.last || axi.wstrb !== 4'hf) begin n_fail++; $display("FAIL lw_beat%0d: got data=%h last=%b strb=%h want %h %b f", beats, axi.wdata, axi.wlast, axi.wstrb, exp_b.data, exp_b.last); end
                end
                beats++;
            end
            tick();
        end
        axi.wready = 1'b0;
        #1;
        n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL lw_beat_count: got %0d want 4", beats); end
        n_checks++; if (axi.wvalid !== 1'b0 || axi.bready !== 1'b1 || wr_rdy !== 1'b0) begin n_fail++; $display("FAIL lw_resp_wait: got wvalid=%b bready=%b wr_rdy=%b want 0 1 0", axi.wvalid, axi.bready, wr_rdy); end
        tick();
        axi.bvalid = 1'b1;
        #1;
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL lw_rdy_during_b: got %b want 0", wr_rdy); end
        tick();
        axi.bvalid = 1'b0;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || axi.bready !== 1'b0) begin n_fail++; $display("FAIL lw_done: got wr_rdy=%b bready=%b want 1 0", wr_rdy, axi.bready); end
        sb.delete();
    endtask

    task automatic test_raw_hazard();
        wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0300; wr_wstrb = 4'h3;
        wr_data = {96'h0, 32'h0000_CAFE};
        sb.push_back('{data: 32'h0000_CAFE, last: 1'b1});
        tick();
        wr_req = 1'b0;
        rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0300;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL raw_aw_phase: got rd_rdy=%b want 0", rd_rdy); end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        axi.wready = 1'b1;
        #1;
        if (axi.wvalid && sb.size() > 0) begin
            exp_b = sb.pop_front();
            n_checks++; if (axi.wdata !== exp_b.data || axi.wlast !== exp_b.last || axi.wstrb !== 4'h3) begin n_fail++; $display("FAIL raw_wbeat: got data=%h last=%b strb=%h want %h %b 3", axi.wdata, axi.wlast, axi.wstrb, exp_b.data, exp_b.last); end
        end else begin
            n_checks++; n_fail++; $display("FAIL raw_wvalid: got wvalid=%b want 1", axi.wvalid);
        end
        tick();
        axi.wready = 1'b0;
        #1;
        n_checks++; if (axi.bready !== 1'b1 || rd_rdy !== 1'b0) begin n_fail++; $display("FAIL raw_resp_phase: got bready=%b rd_rdy=%b want 1 0", axi.bready, rd_rdy); end
        rd_addr = 32'h0000_0400;
        #1;
        n_checks++; if (rd_rdy !== LINE_CHK) begin n_fail++; $display("FAIL raw_other_line: got rd_rdy=%b want %b", rd_rdy, LINE_CHK); end
        rd_addr = 32'h0000_0300;
        axi.bvalid = 1'b1;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL raw_during_b: got rd_rdy=%b want 0", rd_rdy); end
        tick();
        axi.bvalid = 1'b0;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL raw_after_b: got rd_rdy=%b want 1", rd_rdy); end
        tick();
        rd_req = 1'b0;
        drain_read(1);
        sb.delete();
    endtask

    task automatic test_simultaneous();
        wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h0000_0500; wr_wstrb = 4'hf;
        wr_data = {32'h4, 32'h3, 32'h2, 32'h1};
        rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0504;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0) begin n_fail++; $display("FAIL sim_same_line: got wr_rdy=%b rd_rdy=%b want 1 0", wr_rdy, rd_rdy); end
        tick();
        wr_req = 1'b0;
        #1;
        n_checks++; if (axi.awvalid !== 1'b1 || axi.arvalid !== 1'b0 || rd_rdy !== 1'b0) begin n_fail++; $display("FAIL sim_same_after: got awvalid=%b arvalid=%b rd_rdy=%b want 1 0 0", axi.awvalid, axi.arvalid, rd_rdy); end
        rd_req = 1'b0;
        drain_write(4);
        wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0600;
        rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0700;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || rd_rdy !== LINE_CHK) begin n_fail++; $display("FAIL sim_diff_line: got wr_rdy=%b rd_rdy=%b want 1 %b", wr_rdy, rd_rdy, LINE_CHK); end
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        n_checks++; if (axi.awvalid !== 1'b1 || axi.arvalid !== LINE_CHK) begin n_fail++; $display("FAIL sim_diff_after: got awvalid=%b arvalid=%b want 1 %b", axi.awvalid, axi.arvalid, LINE_CHK); end
        drain_write(1);
        if (LINE_CHK) drain_read(1);
    endtask

    task automatic test_reset_mid_burst();
        rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h1c00_0200;
        tick();
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{data: 32'hB0 + i, last: (i == 3)});
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.rvalid = 1'b1; axi.rdata = 32'hB0 + i; axi.rlast = 1'b0;
            if (i == 1) resetn = 1'b0;
            #1;
            if (ret_valid && sb.size() > 0) begin
                exp_b = sb.pop_front();
                n_checks++; if (ret_data !== exp_b.data || ret_last !== exp_b.last) begin n_fail++; $display("FAIL rst_beat%0d: got data=%h last=%b want %h %b", i, ret_data, ret_last, exp_b.data, exp_b.last); end
            end else begin
                n_checks++; n_fail++; $display("FAIL rst_beat%0d_valid: got ret_valid=%b want 1", i, ret_valid);
            end
            tick();
        end
        sb.delete();
        n_checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || ret_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got arvalid=%b rready=%b ret_valid=%b want 0 0 0", axi.arvalid, axi.rready, ret_valid); end
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rd_rdy: got %b want 1", rd_rdy); end
        axi.rvalid = 1'b0;
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        axi.arready = 1'b0;
        axi.rid = 4'd0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bid = 4'd1; axi.bresp = 2'b00; axi.bvalid = 1'b0;

        test_reset();
        test_line_read();
        test_word_read();
        test_line_write();
        test_raw_hazard();
        test_simultaneous();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
